// File: rtl/operand_fetch_pkg.sv
// Shared types and default widths for the operand fetch stage.
package operand_fetch_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_READ  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/operand_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set beats clear on the same edge.
// Hazard query treats a same-cycle writeback to the source as already resolved.
module operand_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_set_vld,
  input  logic [ADDR_W-1:0]        i_set_addr,
  input  logic                     i_clr_vld,
  input  logic [ADDR_W-1:0]        i_clr_addr,
  input  logic [ADDR_W-1:0]        i_q_addr1,
  input  logic [ADDR_W-1:0]        i_q_addr2,
  output logic [(1<<ADDR_W)-1:0]   o_busy_vec,
  output logic                     o_q_clear1,
  output logic                     o_q_clear2
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;

  assign w_set_mask = i_set_vld ? (NREG'(1) << i_set_addr) : '0;
  assign w_clr_mask = i_clr_vld ? (NREG'(1) << i_clr_addr) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end
  end

  assign o_busy_vec = r_busy;
  assign o_q_clear1 = ~r_busy[i_q_addr1] | (i_clr_vld && (i_clr_addr == i_q_addr1));
  assign o_q_clear2 = ~r_busy[i_q_addr2] | (i_clr_vld && (i_clr_addr == i_q_addr2));

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: waits out RAW hazards, reads the registered-read register file, bypasses writebacks.
// Unstalled: accept at edge N, operands presented from edge N+2, visible to the consumer at edge N+3.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_rs1,
  input  logic [ADDR_W-1:0]        req_rs2,
  input  logic [ADDR_W-1:0]        req_rd,
  input  logic                     req_rd_wr,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [DATA_W-1:0]        op_a,
  output logic [DATA_W-1:0]        op_b,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     rf_read_enable,
  output logic [ADDR_W-1:0]        rf_addr1,
  output logic [ADDR_W-1:0]        rf_addr2,
  input  logic [DATA_W-1:0]        rf_out1,
  input  logic [DATA_W-1:0]        rf_out2,
  output logic                     rf_write_enable,
  output logic [ADDR_W-1:0]        rf_in_addr,
  output logic [DATA_W-1:0]        rf_in_data,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  state_e r_state;
  state_e w_state_nxt;

  logic [ADDR_W-1:0] r_rs1, r_rs2, r_rd;
  logic              r_rd_wr;
  logic              r_byp1_vld, r_byp2_vld;
  logic [DATA_W-1:0] r_byp_dat;
  logic [DATA_W-1:0] r_op_a, r_op_b;

  logic w_accept, w_clear1, w_clear2, w_go, w_wb_hit1, w_wb_hit2, w_sb_set;

  assign w_accept  = req_valid & req_ready;
  assign w_wb_hit1 = wb_valid && (wb_addr == r_rs1);
  assign w_wb_hit2 = wb_valid && (wb_addr == r_rs2);
  assign w_go      = (r_state == S_CHECK) & w_clear1 & w_clear2;
  assign w_sb_set  = (r_state == S_READ) & r_rd_wr;

  operand_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_set_vld  (w_sb_set),
    .i_set_addr (r_rd),
    .i_clr_vld  (wb_valid),
    .i_clr_addr (wb_addr),
    .i_q_addr1  (r_rs1),
    .i_q_addr2  (r_rs2),
    .o_busy_vec (busy_vec),
    .o_q_clear1 (w_clear1),
    .o_q_clear2 (w_clear2)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CHECK;
      S_CHECK: if (w_go)     w_state_nxt = S_READ;
      S_READ:                w_state_nxt = S_OUT;
      S_OUT:   if (op_ready) w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready      = 1'b0;
    rf_read_enable = 1'b0;
    op_valid       = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE:  req_ready      = 1'b1;
        S_CHECK: rf_read_enable = w_go;
        S_OUT:   op_valid       = 1'b1;
        default: ;
      endcase
    end
  end

  // A writeback in the read-issue cycle lands in the RF too late for the read; remember it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rd_wr    <= 1'b0;
      r_byp1_vld <= 1'b0;
      r_byp2_vld <= 1'b0;
      r_byp_dat  <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
    end else begin
      if (w_accept) begin
        r_rs1   <= req_rs1;
        r_rs2   <= req_rs2;
        r_rd    <= req_rd;
        r_rd_wr <= req_rd_wr;
      end
      if (w_go) begin
        r_byp1_vld <= w_wb_hit1;
        r_byp2_vld <= w_wb_hit2;
        r_byp_dat  <= wb_data;
      end
      if (r_state == S_READ) begin
        r_op_a <= w_wb_hit1 ? wb_data : (r_byp1_vld ? r_byp_dat : rf_out1);
        r_op_b <= w_wb_hit2 ? wb_data : (r_byp2_vld ? r_byp_dat : rf_out2);
      end
    end
  end

  assign op_a            = r_op_a;
  assign op_b            = r_op_b;
  assign rf_addr1        = r_rs1;
  assign rf_addr2        = r_rs2;
  assign rf_write_enable = wb_valid & ~reset;
  assign rf_in_addr      = wb_addr;
  assign rf_in_data      = wb_data;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch paired with a registered-read register file (cleared on reset).
module tb_operand_fetch;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_rd_wr;
  logic [AW-1:0] req_rs1, req_rs2, req_rd;
  logic          op_valid, op_ready;
  logic [DW-1:0] op_a, op_b;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          rf_read_enable, rf_write_enable;
  logic [AW-1:0] rf_addr1, rf_addr2, rf_in_addr;
  logic [DW-1:0] rf_out1, rf_out2, rf_in_data;
  logic [31:0]   busy_vec;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural register values and the set of registers with a pending write.
  logic [DW-1:0] model_rf [32];
  logic [31:0]   model_pend;

  logic [DW-1:0] rf_mem [32];

  always #5 clk = ~clk;

  operand_fetch #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_rd_wr(req_rd_wr),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_read_enable(rf_read_enable), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_out1(rf_out1), .rf_out2(rf_out2),
    .rf_write_enable(rf_write_enable), .rf_in_addr(rf_in_addr), .rf_in_data(rf_in_data),
    .busy_vec(busy_vec)
  );

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else begin
      if (rf_read_enable) begin
        rf_out1 <= rf_mem[rf_addr1];
        rf_out2 <= rf_mem[rf_addr2];
      end
      if (rf_write_enable) rf_mem[rf_in_addr] <= rf_in_data;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    model_pend = '0;
  endtask

  // Drivers: all called and returning at a falling edge.
  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d, input logic w);
    req_valid = 1'b1; req_rs1 = a; req_rs2 = b; req_rd = d; req_rd_wr = w;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clk);
    wb_valid = 1'b0;
    model_rf[a]   = d;
    model_pend[a] = 1'b0;
  endtask

  task automatic wait_op(output int n);
    n = 0;
    while (op_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (op_valid !== 1'b1) n = -1;
  endtask

  task automatic handshake();
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %b expected 0", op_valid); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_vec); end
    checks++; if (op_a !== 32'h0 || op_b !== 32'h0) begin errors++; $display("FAIL reset_ops: got %h/%h expected 0/0", op_a, op_b); end
    checks++; if (rf_read_enable !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rf_read_enable); end
  endtask

  task automatic test_basic_read();
    do_wb(5'd2, 32'd2222);
    issue(5'd0, 5'd2, 5'd0, 1'b0);
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL basic_lat_n1: op_valid %b expected 0", op_valid); end
    @(negedge clk);
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL basic_lat_n2: op_valid %b expected 0", op_valid); end
    @(negedge clk);
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL basic_lat_n3: op_valid %b expected 1", op_valid); end
    checks++; if (op_a !== 32'd0 || op_b !== 32'd2222) begin errors++; $display("FAIL basic_ops: got %0d/%0d expected 0/2222", op_a, op_b); end
    handshake();
    checks++; if (req_ready !== 1'b1 || op_valid !== 1'b0) begin errors++; $display("FAIL basic_after_hs: ready %b valid %b expected 1 0", req_ready, op_valid); end
  endtask

  task automatic test_raw_stall();
    int n;
    issue(5'd1, 5'd1, 5'd5, 1'b1);
    wait_op(n);
    checks++; if (n < 0) begin errors++; $display("FAIL raw_first_timeout: got timeout expected op_valid"); end
    handshake();
    model_pend[5] = 1'b1;
    checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL raw_busy_set: got %b expected 1", busy_vec[5]); end
    issue(5'd5, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (op_valid !== 1'b0 || rf_read_enable !== 1'b0 || busy_vec[5] !== 1'b1) begin
        errors++; $display("FAIL raw_stall[%0d]: valid %b rd_en %b busy5 %b expected 0 0 1", i, op_valid, rf_read_enable, busy_vec[5]);
      end
      @(negedge clk);
    end
    do_wb(5'd5, 32'd1234);
    wait_op(n);
    checks++; if (n != 1) begin errors++; $display("FAIL raw_resume_lat: got %0d expected 1", n); end
    checks++; if (op_a !== 32'd1234) begin errors++; $display("FAIL raw_bypass: got %0d expected 1234", op_a); end
    checks++; if (busy_vec[5] !== 1'b0) begin errors++; $display("FAIL raw_busy_clr: got %b expected 0", busy_vec[5]); end
    handshake();
  endtask

  task automatic test_read_bypass();
    do_wb(5'd7, 32'd1111);
    issue(5'd0, 5'd7, 5'd0, 1'b0);
    checks++; if (rf_read_enable !== 1'b1 || rf_addr2 !== 5'd7) begin errors++; $display("FAIL byp_read_issue: rd_en %b addr2 %0d expected 1 7", rf_read_enable, rf_addr2); end
    @(negedge clk);
    do_wb(5'd7, 32'd5678);
    checks++; if (op_valid !== 1'b1 || op_b !== 32'd5678) begin errors++; $display("FAIL byp_read_stage: valid %b op_b %0d expected 1 5678", op_valid, op_b); end
    handshake();
  endtask

  task automatic test_set_wins();
    issue(5'd0, 5'd0, 5'd3, 1'b1);
    @(negedge clk);
    do_wb(5'd3, 32'd42);
    model_pend[3] = 1'b1;
    checks++; if (busy_vec[3] !== 1'b1 || op_valid !== 1'b1) begin errors++; $display("FAIL set_wins: busy3 %b valid %b expected 1 1", busy_vec[3], op_valid); end
    handshake();
    do_wb(5'd3, 32'd43);
    checks++; if (busy_vec[3] !== 1'b0) begin errors++; $display("FAIL set_wins_later_clr: got %b expected 0", busy_vec[3]); end
  endtask

  task automatic test_backpressure();
    int n;
    do_wb(5'd4, 32'hAAAA);
    do_wb(5'd6, 32'hBBBB);
    issue(5'd4, 5'd6, 5'd0, 1'b0);
    wait_op(n);
    checks++; if (n != 2) begin errors++; $display("FAIL bp_latency: got %0d expected 2", n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (op_a !== 32'hAAAA || op_b !== 32'hBBBB || req_ready !== 1'b0 || op_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: a %h b %h ready %b valid %b expected aaaa bbbb 0 1", i, op_a, op_b, req_ready, op_valid);
      end
      do_wb(5'd4, $urandom);
    end
    handshake();
  endtask

  task automatic test_reset_midop();
    int n;
    issue(5'd0, 5'd0, 5'd9, 1'b1);
    wait_op(n);
    handshake();
    issue(5'd9, 5'd9, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (op_valid !== 1'b0 || busy_vec[9] !== 1'b1) begin errors++; $display("FAIL rst_mid_stalled: valid %b busy9 %b expected 0 1", op_valid, busy_vec[9]); end
    reset = 1'b1; wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'd777;
    #1;
    checks++; if (rf_write_enable !== 1'b0 || rf_read_enable !== 1'b0) begin errors++; $display("FAIL rst_mid_rf_en: we %b re %b expected 0 0", rf_write_enable, rf_read_enable); end
    @(negedge clk);
    reset = 1'b0; wb_valid = 1'b0;
    model_reset();
    #1;
    checks++; if (req_ready !== 1'b1 || busy_vec !== 32'h0 || op_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_after: ready %b busy %h valid %b expected 1 0 0", req_ready, busy_vec, op_valid); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a, b, d, t;
    logic          w, hz;
    int            n;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      a = AW'($urandom_range(7)); b = AW'($urandom_range(7)); d = AW'($urandom_range(7));
      w = 1'($urandom_range(1));
      hz = model_pend[a] | model_pend[b];
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected 1", k, req_ready); end
      issue(a, b, d, w);
      n = 0;
      while (op_valid !== 1'b1 && n < 40) begin
        if ($urandom_range(1) == 1) begin
          if (model_pend[a]) t = a;
          else if (model_pend[b]) t = b;
          else t = AW'($urandom_range(7));
          do_wb(t, $urandom);
        end else begin
          @(negedge clk);
        end
        n++;
      end
      checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL rand_timeout[%0d]: op_valid %b expected 1", k, op_valid); end
      if (!hz) begin
        checks++; if (n != 2) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 2", k, n); end
      end
      checks++;
      if (op_a !== model_rf[a] || op_b !== model_rf[b]) begin
        errors++; $display("FAIL rand_ops[%0d]: got %h/%h expected %h/%h", k, op_a, op_b, model_rf[a], model_rf[b]);
      end
      if (w) model_pend[d] = 1'b1;
      repeat ($urandom_range(2)) @(negedge clk);
      handshake();
      checks++; if (busy_vec !== model_pend) begin errors++; $display("FAIL rand_busy[%0d]: got %h expected %h", k, busy_vec, model_pend); end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_rd_wr = 1'b0;
    op_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_read();
    test_raw_stall();
    test_read_bypass();
    test_set_wins();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
